pipeline_reg: RTL and testbench
===============================

Name: pipeline_reg

Overview:
- Fully registered valid/ready pipeline stage (two-entry skid buffer) that breaks timing on data, valid and ready paths between a producer and a consumer.
- Sustains one transfer per cycle with no bubbles, never drops or duplicates a word, and preserves order.
- Inserted on any streaming datapath boundary that needs a register slice.

Parameters:
- DATA_WIDTH, 32, width of the data payload in bits (must be >= 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream asserts when in_data holds a word.
- in_ready  output  1  stage can accept a word this cycle; driven directly from a flop.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid word; driven directly from a flop.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  DATA_WIDTH  downstream payload; driven directly from a flop.

Behaviour:
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Transfers occur only on the rising clk edge where the handshake is true.
- Storage:
  - Main register (main_data, drives out_data; main_valid drives out_valid).
  - Skid register (skid_data, skid_valid).
  - in_ready is a registered signal equal to the next-state value of !skid_valid.
- Reset (rst=1 at a clk edge), regardless of other inputs, on that edge:
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_data=0, skid_data=0.
  - Any in-flight words are discarded; in_valid during reset is ignored.
- States: EMPTY (main empty, skid empty), BUSY (main full, skid empty), FULL (both full).
- EMPTY:
  - accept -> BUSY, main_data<=in_data.
  - No accept -> stay.
  - pop impossible.
- BUSY:
  - accept & pop -> BUSY, main_data<=in_data (full-throughput case).
  - accept & !pop -> FULL, skid_data<=in_data, in_ready<=0.
  - !accept & pop -> EMPTY.
  - Neither -> hold.
- FULL:
  - in_ready=0, so no accept.
  - pop -> BUSY, main_data<=skid_data, skid_valid<=0, in_ready<=1.
  - No pop -> hold everything.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N (one cycle).
- Throughput: 1 word/cycle when out_ready is held high.
- Stability:
  - While out_valid=1 and out_ready=0, out_data and out_valid must not change.
  - in_ready may drop only after a word has been absorbed into the skid.
- out_valid must not depend combinationally on out_ready, and in_ready must not depend combinationally on in_valid (no combinational paths input->output).
- Ordering: words leave in the order accepted; the skid word is always older than any later accept.
- out_data when out_valid=0 holds the last value (don't-care for consumers); no X propagation after reset.
- Capacity is exactly 2 words; with out_ready=0 the stage accepts at most two words, then deasserts in_ready.

Test Plan:
- Reset then pass-through: rst high 2 cycles.
  - Expect out_valid=0 and in_ready=1 after reset.
  - With out_ready=1, drive in_valid=1, in_data=0xA5A5A247 for one cycle -> out_valid=1, out_data=0xA5A5A247 the next cycle, then out_valid=0.
- Stall:
  - With out_ready=0, present 0x12348378 held valid 3 cycles -> accepted (BUSY), then held word captured into skid (FULL), in_ready=0, out_data stays 0x12348378.
  - Raise out_ready -> two copies drain on consecutive cycles, in_ready returns to 1.
- Back-to-back burst: out_ready=1, drive 0x12348379, 0x1234837A, 0x1234837B on consecutive cycles -> outputs one cycle later, consecutive, in order, in_ready stays 1.
- Random backpressure: random in_valid/out_ready for 10k cycles with incrementing data.
  - Scoreboard: no loss, duplication or reorder.
  - out_data stable during stalls.
  - in_ready=0 only when two words are held.
- Reset mid-operation: fill to FULL with 0x11, 0x22, assert rst one cycle -> out_valid=0, in_ready=1, out_data=0 next cycle; a subsequent word 0x33 passes normally.
- Simultaneous accept and pop in BUSY: hold out_ready=1 and in_valid=1 for 5 cycles -> never enters FULL, in_ready never drops.

Source files
------------

// File: rtl/pipeline_reg.sv
// Two-entry skid-buffer register slice on a valid/ready stream.
// Data, valid and ready outputs all come straight from flops.
module pipeline_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   main_data_q;
  logic [DATA_WIDTH-1:0]   skid_data_q;
  logic                    main_valid_q;
  logic                    in_ready_q;
  logic                    accept;
  logic                    pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid_q & out_ready;

  // in_ready_q is the inverted skid-valid flag; FULL is the only state holding a skid word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_q  <= in_data;
            main_valid_q <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (accept && pop) begin
            main_data_q <= in_data;
          end else if (accept) begin
            skid_data_q <= in_data;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
          end else if (pop) begin
            main_valid_q <= 1'b0;
            state_q      <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_data_q <= skid_data_q;
            in_ready_q  <= 1'b1;
            state_q     <= BUSY;
          end
        end
        default: begin
          state_q      <= EMPTY;
          main_valid_q <= 1'b0;
          in_ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: tb/tb_pipeline_reg.sv
// Self-checking bench for pipeline_reg: directed scenarios plus random
// backpressure against a queue-based model of a 2-word in-order buffer.
module tb_pipeline_reg;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] next_word;
  bit            saw_stall_ready_drop;

  pipeline_reg #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"},  DW'(in_ready),  DW'(model_q.size() < 2));
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(model_q.size() > 0));
    chk({tag, ".out_data"},  out_data,       exp_data);
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, update the model, check.
  task automatic step(input logic r, input logic iv, input logic [DW-1:0] id,
                      input logic ordy, input string tag);
    bit acc, pp;
    rst       = r;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    acc = iv && (model_q.size() < 2);
    pp  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (r) begin
      model_q.delete();
      exp_data = '0;
    end else begin
      if (pp)  void'(model_q.pop_front());
      if (acc) model_q.push_back(id);
      if (model_q.size() > 0) exp_data = model_q[0];
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, "rst0");
    step(1'b1, 1'b0, '0, 1'b0, "rst1");
    chk("rst.out_data_zero", out_data, '0);

    // pass-through
    step(1'b0, 1'b1, 32'hA5A5_A247, 1'b1, "pass_in");
    chk("pass.data", out_data, 32'hA5A5_A247);
    step(1'b0, 1'b0, '0, 1'b1, "pass_out");
    chk("pass.valid_low", DW'(out_valid), '0);

    // stall: same word held valid for 3 cycles with out_ready low
    for (int unsigned i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h1234_8378, 1'b0, "stall");
    chk("stall.in_ready_low", DW'(in_ready), '0);
    chk("stall.data", out_data, 32'h1234_8378);
    step(1'b0, 1'b0, '0, 1'b1, "drain0");
    chk("drain0.in_ready", DW'(in_ready), 1);
    step(1'b0, 1'b0, '0, 1'b1, "drain1");

    // back-to-back burst
    for (int unsigned i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h1234_8379 + i, 1'b1, "burst");
    chk("burst.last", out_data, 32'h1234_837B);
    step(1'b0, 1'b0, '0, 1'b1, "burst_end");

    // reset mid-operation from FULL
    step(1'b0, 1'b1, 32'h11, 1'b0, "fill0");
    step(1'b0, 1'b1, 32'h22, 1'b0, "fill1");
    chk("fill.in_ready_low", DW'(in_ready), '0);
    step(1'b1, 1'b1, 32'h99, 1'b1, "midrst");
    chk("midrst.out_data", out_data, '0);
    step(1'b0, 1'b1, 32'h33, 1'b1, "post_rst");
    chk("post_rst.data", out_data, 32'h33);
    step(1'b0, 1'b0, '0, 1'b1, "post_rst_end");

    // accept and pop together in BUSY: never fills
    for (int unsigned i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h5000 + i, 1'b1, "simul");
      chk("simul.in_ready", DW'(in_ready), 1);
    end
    step(1'b0, 1'b0, '0, 1'b1, "simul_end");

    // random backpressure with incrementing data
    next_word = 32'h0001_0000;
    saw_stall_ready_drop = 1'b0;
    for (int unsigned i = 0; i < 10000; i++) begin
      bit iv, ordy, acc;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      acc  = iv && (model_q.size() < 2);
      step(1'b0, iv, next_word, ordy, "rand");
      if (acc) next_word = next_word + 1;
      if (!in_ready) saw_stall_ready_drop = 1'b1;
    end
    for (int unsigned i = 0; i < 3; i++)
      step(1'b0, 1'b0, '0, 1'b1, "rand_drain");
    chk("rand.reached_full", DW'(saw_stall_ready_drop), 1);
    chk("rand.empty_at_end", DW'(out_valid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
